ysyx_25020047_ifu: RTL and testbench
====================================

// Module: ysyx_25020047_ifu
// PURPOSE
//   Instruction fetch unit, directly upstream of the decode stage. Reads the current PC
//   and fetches one word from instruction memory over a req/ack handshake. It holds the
//   fetched word plus a valid flag stable for decode until the PC register retires the
//   instruction. Misaligned PCs, bus errors and fetch timeouts are flagged as sticky faults.
// PARAMETERS
//   NOP_INST   32'h00000013  value driven on inst while no valid instruction (addi x0,x0,0)
//   TIMER_W    8             width of wait-cycle counter
//   TIMEOUT    255           max WAIT cycles before timeout fault; 0 disables timeout
// PORTS
//   clk          in   1   clock, rising edge
//   rst          in   1   synchronous reset, active-low (rst==0 resets on next edge)
//   pc           in   32  current PC from PC register
//   pc_update    in   1   pulse: PC register loaded dnpc this cycle (instruction retired)
//   imem_req     out  1   fetch request to instruction memory
//   imem_addr    out  32  fetch address, stable while imem_req==1
//   imem_ack     in   1   memory response valid (sampled only in WAIT)
//   imem_rdata   in   32  fetched word, valid when imem_ack==1
//   imem_err     in   1   bus error, qualified by imem_ack
//   inst         out  32  instruction to decode
//   inst_valid   out  1   inst/inst_pc hold a valid fetched instruction
//   inst_pc      out  32  address the current inst was fetched from
//   fetch_fault  out  1   sticky fault flag
//   fault_cause  out  2   0 none, 1 misaligned pc, 2 bus error, 3 timeout
// BEHAVIOUR
//   All outputs registered. Reset (rst==0 at edge): state=IDLE, imem_req=0, imem_addr=0,
//     inst=NOP_INST, inst_valid=0, inst_pc=0, fetch_fault=0, fault_cause=0, timer=0.
//     Reset wins over every other event, in any state, including mid-WAIT.
//   FSM states: IDLE, WAIT, HOLD, FAULT.
//   IDLE: at next edge, if pc[1:0]!=0 -> FAULT, fault_cause=1. Otherwise imem_addr<=pc,
//     imem_req<=1, timer<=0 -> WAIT.
//   WAIT: imem_req and imem_addr held constant until ack. Edge with imem_ack=1:
//     imem_err=0 -> inst<=imem_rdata, inst_pc<=imem_addr, inst_valid<=1, imem_req<=0 -> HOLD.
//     imem_err=1 -> imem_req<=0, fetch_fault<=1, fault_cause<=2 -> FAULT.
//     Edge with imem_ack=0: timer<=timer+1. If TIMEOUT!=0 and timer==TIMEOUT-1 at that
//     edge -> imem_req<=0, fault_cause<=3 -> FAULT. Timer saturates, never wraps.
//   HOLD: inst, inst_pc, inst_valid=1 stable. Edge with pc_update=1 -> inst_valid<=0,
//     inst<=NOP_INST -> IDLE (next fetch uses the updated pc).
//   FAULT: terminal until reset; imem_req=0, inst_valid=0, inst=NOP_INST.
//   Ignored events: imem_ack outside WAIT; pc_update outside HOLD; pc changes outside IDLE.
//   Latency: IDLE edge -> imem_req high; zero-wait ack -> inst_valid high one edge later,
//     i.e. inst_valid asserts 2 cycles after IDLE entry; each ack-wait cycle adds 1.
//   Throughput: one instruction per (3 + wait) cycles when pc_update arrives in 1st HOLD cycle.
//   Single outstanding request only; imem_req never asserted in two consecutive fetches
//     without a deassert cycle between them.
// TESTING
//   Reset: hold rst=0 2 cycles -> inst=0x00000013, inst_valid=0, imem_req=0, fetch_fault=0.
//   Zero-wait fetch: pc=0x80000000, ack=1 first WAIT cycle, rdata=0x00100093 -> imem_addr=
//     0x80000000; inst=0x00100093, inst_pc=0x80000000, inst_valid=1 2 cycles after IDLE.
//   Wait+retire: ack after 3 cycles; pulse pc_update with pc=0x80000004 -> inst_valid drops
//     next edge, next imem_addr=0x80000004.
//   Misaligned: pc=0x80000002 -> imem_req never rises, fetch_fault=1, fault_cause=1.
//   Timeout/err: TIMEOUT=4, no ack -> fault_cause=3 after 4 WAIT cycles, imem_req=0;
//     separately ack=1, err=1 -> fault_cause=2, inst_valid stays 0.
//   Reset mid-WAIT: rst=0 while imem_req=1 -> all outputs at reset values next edge;
//     stray ack afterwards ignored.

Source files
------------

// File: rtl/ysyx_25020047_ifu_if.sv
// Instruction memory fetch channel: single outstanding req/ack transaction.
// The IFU drives req/addr; memory answers with ack, rdata and err.
interface ysyx_25020047_ifu_if;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;
  logic        err;

  modport master (output req, output addr, input ack, input rdata, input err);
  modport slave  (input req, input addr, output ack, output rdata, output err);
endinterface

// File: rtl/ysyx_25020047_ifu.sv
// Instruction fetch unit: fetches one word at pc and holds it for decode until retired.
// Misaligned pc, bus error and fetch timeout latch a sticky fault until reset.
//
//   state | meaning
//   IDLE  | sample pc, launch fetch or flag misalignment
//   WAIT  | request outstanding, counting wait cycles
//   HOLD  | fetched instruction valid, waiting for pc_update
//   FAULT | terminal fault, cleared only by reset
module ysyx_25020047_ifu #(
  parameter logic [31:0] NOP_INST = 32'h0000_0013,
  parameter int          TIMER_W  = 8,
  parameter int          TIMEOUT  = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            pc,
  input  logic                   pc_update,
  ysyx_25020047_ifu_if.master    imem,
  output logic [31:0]            inst,
  output logic                   inst_valid,
  output logic [31:0]            inst_pc,
  output logic                   fetch_fault,
  output logic [1:0]             fault_cause
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    FAULT = 2'd3
  } state_t;

  localparam int                 TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [TIMER_W-1:0] TO_CMP  = TIMER_W'(TO_LAST);
  localparam logic [TIMER_W-1:0] TMR_MAX = '1;

  state_t             state;
  logic [TIMER_W-1:0] timer;
  logic               timeout_hit;

  assign timeout_hit = (TIMEOUT != 0) && (timer == TO_CMP);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      imem.req    <= 1'b0;
      imem.addr   <= 32'd0;
      inst        <= NOP_INST;
      inst_valid  <= 1'b0;
      inst_pc     <= 32'd0;
      fetch_fault <= 1'b0;
      fault_cause <= 2'd0;
      timer       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pc[1:0] != 2'b00) begin
            fetch_fault <= 1'b1;
            fault_cause <= 2'd1;
            state       <= FAULT;
          end else begin
            imem.addr <= pc;
            imem.req  <= 1'b1;
            timer     <= '0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (imem.ack) begin
            imem.req <= 1'b0;
            if (imem.err) begin
              fetch_fault <= 1'b1;
              fault_cause <= 2'd2;
              state       <= FAULT;
            end else begin
              inst       <= imem.rdata;
              inst_pc    <= imem.addr;
              inst_valid <= 1'b1;
              state      <= HOLD;
            end
          end else begin
            if (timer != TMR_MAX) timer <= timer + TIMER_W'(1);
            if (timeout_hit) begin
              imem.req    <= 1'b0;
              fetch_fault <= 1'b1;
              fault_cause <= 2'd3;
              state       <= FAULT;
            end
          end
        end
        HOLD: begin
          if (pc_update) begin
            inst_valid <= 1'b0;
            inst       <= NOP_INST;
            state      <= IDLE;
          end
        end
        default: begin
          // FAULT parks with the bus quiet and decode fed NOPs.
          imem.req   <= 1'b0;
          inst_valid <= 1'b0;
          inst       <= NOP_INST;
          state      <= FAULT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_25020047_ifu.sv
// Directed bench for the instruction fetch unit: one cycle-per-row vector table
// plus short hand sequences for timeout, bus error and reset during a fetch.
module tb_ysyx_25020047_ifu;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        pc_update;
  logic [31:0] inst;
  logic        inst_valid;
  logic [31:0] inst_pc;
  logic        fetch_fault;
  logic [1:0]  fault_cause;

  ysyx_25020047_ifu_if imem_bus ();

  ysyx_25020047_ifu #(
    .NOP_INST (NOP),
    .TIMER_W  (8),
    .TIMEOUT  (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pc          (pc),
    .pc_update   (pc_update),
    .imem        (imem_bus),
    .inst        (inst),
    .inst_valid  (inst_valid),
    .inst_pc     (inst_pc),
    .fetch_fault (fetch_fault),
    .fault_cause (fault_cause)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [31:0] pc;
    logic        upd;
    logic        ack;
    logic [31:0] rdata;
    logic        err;
    logic        req;
    logic [31:0] addr;
    logic [31:0] inst;
    logic        vld;
    logic [31:0] ipc;
    logic        flt;
    logic [1:0]  cause;
  } vec_t;

  vec_t vecs[16];
  int   n_pass = 0;
  int   n_tot  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s actual=%h required=%h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic drive(input logic r, input logic [31:0] p, input logic u,
                       input logic a, input logic [31:0] d, input logic e);
    rst            = r;
    pc             = p;
    pc_update      = u;
    imem_bus.ack   = a;
    imem_bus.rdata = d;
    imem_bus.err   = e;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic req, input logic [31:0] ins,
                         input logic vld, input logic flt, input logic [1:0] cause);
    chk({tag, ".req"},   32'(imem_bus.req), 32'(req));
    chk({tag, ".inst"},  inst,              ins);
    chk({tag, ".valid"}, 32'(inst_valid),   32'(vld));
    chk({tag, ".fault"}, 32'(fetch_fault),  32'(flt));
    chk({tag, ".cause"}, 32'(fault_cause),  32'(cause));
  endtask

  task automatic do_reset();
    drive(1'b0, 32'h8000_0000, 1'b0, 1'b0, 32'd0, 1'b0);
    tick();
    tick();
  endtask

  initial begin
    //            rst pc            upd ack rdata         err | req addr          inst          vld ipc           flt cause
    vecs[0]  = '{1'b0, 32'h8000_0000, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         NOP,           1'b0, 32'h0,         1'b0, 2'd0};
    vecs[1]  = '{1'b0, 32'h8000_0000, 1'b0, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 32'h0,         NOP,           1'b0, 32'h0,         1'b0, 2'd0};
    vecs[2]  = '{1'b1, 32'h8000_0000, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h8000_0000, NOP,           1'b0, 32'h0,         1'b0, 2'd0};
    vecs[3]  = '{1'b1, 32'h8000_0000, 1'b0, 1'b1, 32'h0010_0093, 1'b0, 1'b0, 32'h8000_0000, 32'h0010_0093, 1'b1, 32'h8000_0000, 1'b0, 2'd0};
    vecs[4]  = '{1'b1, 32'h8000_0000, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h8000_0000, 32'h0010_0093, 1'b1, 32'h8000_0000, 1'b0, 2'd0};
    vecs[5]  = '{1'b1, 32'h8000_0004, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h8000_0000, NOP,           1'b0, 32'h8000_0000, 1'b0, 2'd0};
    vecs[6]  = '{1'b1, 32'h8000_0004, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h8000_0004, NOP,           1'b0, 32'h8000_0000, 1'b0, 2'd0};
    vecs[7]  = '{1'b1, 32'h8000_0008, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h8000_0004, NOP,           1'b0, 32'h8000_0000, 1'b0, 2'd0};
    vecs[8]  = '{1'b1, 32'h8000_000C, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'h8000_0004, NOP,           1'b0, 32'h8000_0000, 1'b0, 2'd0};
    vecs[9]  = '{1'b1, 32'h8000_0004, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h8000_0004, NOP,           1'b0, 32'h8000_0000, 1'b0, 2'd0};
    vecs[10] = '{1'b1, 32'h8000_0004, 1'b0, 1'b1, 32'h0020_0113, 1'b0, 1'b0, 32'h8000_0004, 32'h0020_0113, 1'b1, 32'h8000_0004, 1'b0, 2'd0};
    vecs[11] = '{1'b1, 32'h1234_5678, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h8000_0004, 32'h0020_0113, 1'b1, 32'h8000_0004, 1'b0, 2'd0};
    vecs[12] = '{1'b1, 32'h8000_0002, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h8000_0004, NOP,           1'b0, 32'h8000_0004, 1'b0, 2'd0};
    vecs[13] = '{1'b1, 32'h8000_0002, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h8000_0004, NOP,           1'b0, 32'h8000_0004, 1'b1, 2'd1};
    vecs[14] = '{1'b1, 32'h8000_0000, 1'b1, 1'b1, 32'h0030_0193, 1'b0, 1'b0, 32'h8000_0004, NOP,           1'b0, 32'h8000_0004, 1'b1, 2'd1};
    vecs[15] = '{1'b0, 32'h8000_0000, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         NOP,           1'b0, 32'h0,         1'b0, 2'd0};

    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    #2;

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].rst, vecs[i].pc, vecs[i].upd, vecs[i].ack, vecs[i].rdata, vecs[i].err);
      tick();
      chk($sformatf("v%0d.req", i),   32'(imem_bus.req), 32'(vecs[i].req));
      chk($sformatf("v%0d.addr", i),  imem_bus.addr,     vecs[i].addr);
      chk($sformatf("v%0d.inst", i),  inst,              vecs[i].inst);
      chk($sformatf("v%0d.valid", i), 32'(inst_valid),   32'(vecs[i].vld));
      chk($sformatf("v%0d.ipc", i),   inst_pc,           vecs[i].ipc);
      chk($sformatf("v%0d.fault", i), 32'(fetch_fault),  32'(vecs[i].flt));
      chk($sformatf("v%0d.cause", i), 32'(fault_cause),  32'(vecs[i].cause));
    end

    // Timeout: with TIMEOUT=4 the fourth unacknowledged WAIT edge faults.
    do_reset();
    drive(1'b1, 32'h8000_0010, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    chk_all("to.launch", 1'b1, NOP, 1'b0, 1'b0, 2'd0);
    for (int w = 1; w <= 3; w++) begin
      tick();
      chk_all($sformatf("to.wait%0d", w), 1'b1, NOP, 1'b0, 1'b0, 2'd0);
    end
    tick();
    chk_all("to.expire", 1'b0, NOP, 1'b0, 1'b1, 2'd3);
    drive(1'b1, 32'h8000_0010, 1'b0, 1'b1, 32'h0040_0213, 1'b0);
    tick();
    chk_all("to.sticky", 1'b0, NOP, 1'b0, 1'b1, 2'd3);

    // Bus error on the first WAIT cycle.
    do_reset();
    drive(1'b1, 32'h8000_0020, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    chk_all("err.launch", 1'b1, NOP, 1'b0, 1'b0, 2'd0);
    drive(1'b1, 32'h8000_0020, 1'b0, 1'b1, 32'h0050_0293, 1'b1);
    tick();
    chk_all("err.ack", 1'b0, NOP, 1'b0, 1'b1, 2'd2);
    chk("err.ipc", inst_pc, 32'h0);

    // Reset during WAIT, then a stray ack that must not complete anything.
    do_reset();
    drive(1'b1, 32'h8000_0030, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    tick();
    chk_all("rw.waiting", 1'b1, NOP, 1'b0, 1'b0, 2'd0);
    chk("rw.addr", imem_bus.addr, 32'h8000_0030);
    drive(1'b0, 32'h8000_0030, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    chk_all("rw.reset", 1'b0, NOP, 1'b0, 1'b0, 2'd0);
    chk("rw.addr0", imem_bus.addr, 32'h0);
    drive(1'b1, 32'h8000_0040, 1'b0, 1'b1, 32'h0060_0313, 1'b0);
    tick();
    chk_all("rw.stray", 1'b1, NOP, 1'b0, 1'b0, 2'd0);
    chk("rw.newaddr", imem_bus.addr, 32'h8000_0040);
    drive(1'b1, 32'h8000_0040, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    chk_all("rw.still", 1'b1, NOP, 1'b0, 1'b0, 2'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
